// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect and the decode handshake.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;

  modport master (
    output imem_req_valid, imem_addr, ins_valid, ins, ins_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, ins_valid, ins, ins_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: credit-limited sequential fetch into a small in-order buffer,
// with redirect flushing both buffered words and responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_r;
  logic [31:0]   rsp_pc_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] occ_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] drop_r;
  logic [31:0]   mem_ins_r [DEPTH];
  logic [31:0]   mem_pc_r  [DEPTH];

  logic [CW:0]   credit_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_ok_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   target_s;
  logic          unused_s;

  // Buffered plus in-flight words may never exceed DEPTH, so the buffer cannot overflow.
  assign credit_s    = {1'b0, occ_r} + {1'b0, outst_r};
  assign req_valid_s = rst && !bus.redirect_valid && (credit_s < (CW+1)'(DEPTH));
  assign req_fire_s  = req_valid_s && bus.imem_req_ready;
  assign rsp_ok_s    = bus.imem_rsp_valid && (outst_r != {CW{1'b0}});
  assign push_s      = rsp_ok_s && (drop_r == {CW{1'b0}}) && !bus.redirect_valid;
  assign pop_s       = (occ_r != {CW{1'b0}}) && bus.ins_ready && !bus.redirect_valid;
  assign target_s    = {bus.redirect_pc[31:2], 2'b00};
  assign unused_s    = ^bus.redirect_pc[1:0];

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_addr      = pc_r;
  assign bus.ins_valid      = (occ_r != {CW{1'b0}});
  assign bus.ins            = mem_ins_r[head_r];
  assign bus.ins_pc         = mem_pc_r[head_r];

  // Fetch PC, credit counters, drop counter and instruction buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r     <= RESET_PC;
      rsp_pc_r <= RESET_PC;
      head_r   <= {AW{1'b0}};
      tail_r   <= {AW{1'b0}};
      occ_r    <= {CW{1'b0}};
      outst_r  <= {CW{1'b0}};
      drop_r   <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_ins_r[i] <= 32'h0000_0000;
        mem_pc_r[i]  <= 32'h0000_0000;
      end
    end else begin
      outst_r <= outst_r + CW'(req_fire_s) - CW'(rsp_ok_s);
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the old path and must be swallowed.
        pc_r     <= target_s;
        rsp_pc_r <= target_s;
        head_r   <= {AW{1'b0}};
        tail_r   <= {AW{1'b0}};
        occ_r    <= {CW{1'b0}};
        drop_r   <= outst_r - CW'(rsp_ok_s);
      end else begin
        if (req_fire_s) begin
          pc_r <= pc_r + 32'd4;
        end
        if (rsp_ok_s && (drop_r != {CW{1'b0}})) begin
          drop_r <= drop_r - {{(CW-1){1'b0}}, 1'b1};
        end
        if (push_s) begin
          mem_ins_r[tail_r] <= bus.imem_rsp_data;
          mem_pc_r[tail_r]  <= rsp_pc_r;
          tail_r            <= tail_r + AW'(1'b1);
          rsp_pc_r          <= rsp_pc_r + 32'd4;
        end
        if (pop_s) begin
          head_r <= head_r + AW'(1'b1);
        end
        occ_r <= occ_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    bus.imem_rsp_valid |-> (outst_r != {CW{1'b0}}));
  a_credit: assert property (@(posedge clk) disable iff (!rst)
    credit_s <= (CW+1)'(DEPTH));
endmodule
